muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage. Accepts two XLEN-bit operands and a funct3-encoded operation, computes the result over a fixed number of cycles, and presents it with a one-cycle `done` pulse. `done` drives the `we` of the downstream destination `Register`, and `result` drives its `data_in`. `busy` stalls the sequencer while an operation is in flight.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: register width, M-extension funct3 encodings and
// the multiply/divide sequencer states.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and special cases applied in FIX.
module muldiv_unit #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import rv32_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     opa;
  logic [XLEN-1:0]     opb;
  logic [2*XLEN-1:0]   acc;
  logic                a_neg;
  logic                res_neg;
  logic                b_zero;
  logic                ovf;

  logic                a_signed, b_signed, a_neg_in, b_neg_in, ovf_in;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic [XLEN:0]       mul_sum, div_trial, div_diff;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   acc_next;

  function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v,
                                                 input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v,
                                               input logic en);
    return en ? -v : v;
  endfunction

  // Final result selection, including divide-by-zero and signed overflow.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2:0]        f_op,
    input logic [2*XLEN-1:0] f_acc,
    input logic              f_a_neg,
    input logic              f_res_neg,
    input logic              f_b_zero,
    input logic              f_ovf,
    input logic [XLEN-1:0]   f_a
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    prod = neg_wide(f_acc, f_res_neg);
    quo  = neg_word(f_acc[XLEN-1:0], f_res_neg);
    rem  = neg_word(f_acc[2*XLEN-1:XLEN], f_a_neg);
    unique case (f_op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        res = f_b_zero ? '1 : (f_ovf ? {1'b1, {(XLEN-1){1'b0}}} : quo);
      default:
        res = f_b_zero ? f_a : (f_ovf ? '0 : rem);
    endcase
    return res;
  endfunction

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg_in = a_signed & a[XLEN-1];
    b_neg_in = b_signed & b[XLEN-1];
    a_abs    = neg_word(a, a_neg_in);
    b_abs    = neg_word(b, b_neg_in);
    ovf_in   = ((op == OP_DIV) || (op == OP_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  end

  // One iteration: multiply adds into the high half and shifts right;
  // divide shifts the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (opa[0] ? {1'b0, opb} : '0);
    div_trial = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    div_diff  = div_trial - {1'b0, opb};
    div_rem   = div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
    if (op_q[2]) acc_next = {div_rem, acc[XLEN-2:0], ~div_diff[XLEN]};
    else         acc_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Datapath registers: loaded on acceptance, advanced during CALC.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_q    <= op;
      a_q     <= a;
      opa     <= a_abs;
      opb     <= b_abs;
      acc     <= '0;
      a_neg   <= a_neg_in;
      res_neg <= a_neg_in ^ b_neg_in;
      b_zero  <= (b == '0);
      ovf     <= ovf_in;
    end else if (state == CALC) begin
      acc <= acc_next;
      opa <= op_q[2] ? (opa << 1) : (opa >> 1);
    end
  end

  // Control sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state <= CALC;
          busy  <= 1'b1;
          count <= '0;
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_result(op_q, acc, a_neg, res_neg, b_zero, ovf, a_q);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected result and
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done got_result=%h want=no_done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, result, e.res);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic issue(input logic [2:0] f_op, input logic [31:0] fa,
                       input logic [31:0] fb, input logic [31:0] want,
                       input string name);
    exp_t e;
    start = 1'b1;
    op = f_op;
    a = fa;
    b = fb;
    e.res = want;
    e.cyc = cyc + 34;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_busy_window"}, 32'(busy_ok && !busy), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] f_op, input logic [31:0] fa,
                     input logic [31:0] fb, input logic [31:0] want, input string name);
    vec_t v;
    v.op = f_op; v.a = fa; v.b = fb; v.want = want; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    add(OP_MUL,    32'd7,          32'd6,          32'd42,         "mul_7x6");
    add(OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   "mulh_m1xm1");
    add(OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   "mulhu_max");
    add(OP_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   "mulhsu_m1x2");
    add(OP_MUL,    32'hFFFFFFFF,   32'd3,          32'hFFFFFFFD,   "mul_m1x3");
    add(OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "div_m7_2");
    add(OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "rem_m7_2");
    add(OP_DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   "div_7_m2");
    add(OP_REM,    32'd7,          32'hFFFFFFFE,   32'd1,          "rem_7_m2");
    add(OP_DIVU,   32'd100,        32'd7,          32'd14,         "divu_100_7");
    add(OP_REMU,   32'd100,        32'd7,          32'd2,          "remu_100_7");
    add(OP_DIV,    32'd5,          32'd0,          32'hFFFFFFFF,   "div_by_zero");
    add(OP_REMU,   32'd5,          32'd0,          32'd5,          "remu_by_zero");
    add(OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "div_overflow");
    add(OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,          "rem_overflow");

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].want, vecs[i].name);
      wait_done(vecs[i].name);
      @(negedge clk);
      check({vecs[i].name, "_hold"}, result, vecs[i].want);
      check({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
    end

    // start during CALC with other operands must be ignored
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "ignore_mid_start");
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
    wait_done("ignore_mid_start");

    // back-to-back: start presented in the done cycle
    @(negedge clk);
    issue(OP_MUL, 32'd7, 32'd6, 32'd42, "b2b_first");
    wait_done("b2b_first");
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, "b2b_second");
    wait_done("b2b_second");
    @(negedge clk);

    // reset at iteration 10 aborts with no done
    start = 1'b1; op = OP_MUL; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(OP_MUL, 32'd3, 32'd3, 32'd9, "mul_after_abort");
    wait_done("mul_after_abort");
    @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
